// File: rtl/aes_round_engine.sv
// Iterative AES round engine: one round per clock, AES-128/192/256 selected by X,
// encrypt or decrypt chosen per block by the mode bit latched at accept.
module aes_round_engine #(
  parameter int X = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [0:127]              in_data,
  input  logic                      mode,
  input  logic [0:128*(11+2*X)-1]   words,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [0:127]              out_data,
  output logic                      busy,
  output logic [3:0]                round_idx
);
  localparam int NR = 10 + 2 * X;
  localparam int NW = NR + 1;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 by square-and-multiply; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [0:127]      blk_reg, blk_next;
  logic [0:128*NW-1] keys_reg, keys_next;
  logic              mode_reg, mode_next;
  logic [3:0]        round_reg, round_next;
  logic              load;

  logic [7:0]   cur [16];
  logic [7:0]   sb  [16];
  logic [7:0]   sr  [16];
  logic [7:0]   isr [16];
  logic [7:0]   isb [16];
  logic [0:127] mc_v, enc_pre, enc_out, dec_ark, dec_mix, dec_out, rk_enc, rk_dec;
  logic         last_round;

  // Encrypt and decrypt step on the same round counter; the final step of
  // either direction (r = Nr, k = 0) drops the (Inv)MixColumns stage.
  assign last_round = (round_reg == 4'(NR));
  assign rk_enc     = keys_reg[128*int'(round_reg) +: 128];
  assign rk_dec     = keys_reg[128*(NR - int'(round_reg)) +: 128];

  // Byte n sits at row n%4, column n/4 of the AES state.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign cur[gi] = blk_reg[8*gi +: 8];
    assign sb[gi]  = sbox(cur[gi]);
    assign sr[gi]  = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
    assign enc_pre[8*gi +: 8] = last_round ? sr[gi] : mc_v[8*gi +: 8];
    assign isr[gi] = cur[(gi % 4) + 4 * (((gi / 4) + 4 - (gi % 4)) % 4)];
    assign isb[gi] = inv_sbox(isr[gi]);
    assign dec_ark[8*gi +: 8] = isb[gi] ^ rk_dec[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign mc_v[32*gi +: 32]    = mix_col({sr[4*gi], sr[4*gi+1], sr[4*gi+2], sr[4*gi+3]});
    assign dec_mix[32*gi +: 32] = inv_mix_col(dec_ark[32*gi +: 32]);
  end

  assign enc_out = enc_pre ^ rk_enc;
  assign dec_out = last_round ? dec_ark : dec_mix;

  always_comb begin
    state_next = state_reg;
    blk_next   = blk_reg;
    keys_next  = keys_reg;
    mode_next  = mode_reg;
    round_next = round_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      RUN: begin
        busy     = 1'b1;
        blk_next = mode_reg ? dec_out : enc_out;
        if (last_round) begin
          state_next = DONE;
          round_next = 4'd0;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_next = IDLE;
          load       = in_valid;
        end
      end
      default: state_next = IDLE;
    endcase
    // Accept from IDLE or straight out of DONE (back-to-back).
    if (load) begin
      keys_next  = words;
      mode_next  = mode;
      blk_next   = in_data ^ (mode ? words[128*NR +: 128] : words[0 +: 128]);
      round_next = 4'd1;
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      blk_reg   <= '0;
      keys_reg  <= '0;
      mode_reg  <= 1'b0;
      round_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      blk_reg   <= blk_next;
      keys_reg  <= keys_next;
      mode_reg  <= mode_next;
      round_reg <= round_next;
    end
  end

  assign out_data  = out_valid ? blk_reg : '0;
  assign round_idx = round_reg;
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 vectors on all three key sizes,
// back-to-back with backpressure, input isolation and mid-block reset.
`timescale 1ns/1ps
module tb_aes_round_engine;
  localparam logic [0:127] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [7:0]   AFF_C  = 8'h63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [0:127]  in_data;
  logic          mode;
  logic          in_valid  [3];
  logic          out_ready [3];
  logic          in_ready  [3];
  logic          out_valid [3];
  logic          busy      [3];
  logic [0:127]  out_data  [3];
  logic [3:0]    round_idx [3];
  logic [0:1919] words     [3];
  logic [0:1919] wk        [3];
  logic [7:0]    sbox_t    [256];

  int tests_run = 0;
  int tests_failed = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_round_engine #(.X(gi)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
      .in_data(in_data), .mode(mode),
      .words(words[gi][0:128*(11+2*gi)-1]),
      .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
      .out_data(out_data[gi]), .busy(busy[gi]), .round_idx(round_idx[gi])
    );
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box table from a brute-force field inverse and the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = AFF_C;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  function automatic logic [0:1919] expand(input int x);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1919] r;
    int nk;
    int nr;
    nk = 4 + 2 * x;
    nr = 10 + 2 * x;
    rcon = 8'h01;
    r = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = KEY[32*i +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4 * (nr + 1); i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block from IDLE with out_ready held 1; checks accept, latency, busy, data.
  task automatic run_block(input int k, input logic m, input logic [0:127] din,
                           input logic [0:127] exp, input string name);
    int lat;
    int busy_cnt;
    logic zero_ok;
    in_data = din; mode = m; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    tests_run++;
    if (in_ready[k] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready[k]);
    end
    tick();
    in_valid[k] = 1'b0;
    tests_run++;
    if (round_idx[k] !== 4'd1) begin
      tests_failed++;
      $display("FAIL %s round_idx after accept: got %0d want 1", name, round_idx[k]);
    end
    lat = 1; busy_cnt = 0; zero_ok = 1'b1;
    while (out_valid[k] !== 1'b1 && lat < 100) begin
      if (busy[k] === 1'b1) busy_cnt++;
      if (out_data[k] !== 128'h0) zero_ok = 1'b0;
      tick();
      lat++;
    end
    $display("[TB] %s x=%0d mode=%0d out=%h latency=%0d", name, k, m, out_data[k], lat);
    tests_run++;
    if (lat != 11 + 2 * k) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, 11 + 2 * k);
    end
    tests_run++;
    if (out_data[k] !== exp) begin
      tests_failed++;
      $display("FAIL %s out_data: got %h want %h", name, out_data[k], exp);
    end
    tests_run++;
    if (busy_cnt != 10 + 2 * k || zero_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s busy/idle-data: busy cycles %0d want %0d, out_data zero while running %b want 1",
               name, busy_cnt, 10 + 2 * k, zero_ok);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset x=%0d flags: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                 k, in_ready[k], out_valid[k], busy[k]);
      end
      tests_run++;
      if (round_idx[k] !== 4'd0 || out_data[k] !== 128'h0) begin
        tests_failed++;
        $display("FAIL reset x=%0d values: round_idx=%0d out_data=%h want 0 0", k, round_idx[k], out_data[k]);
      end
    end
    $display("[TB] reset released");
  endtask

  task automatic test_aes128();
    run_block(0, 1'b0, PT, CT128, "aes128_enc");
    run_block(0, 1'b1, CT128, PT, "aes128_dec");
  endtask

  task automatic test_aes192_256();
    run_block(1, 1'b0, PT, CT192, "aes192_enc");
    run_block(1, 1'b1, CT192, PT, "aes192_dec");
    run_block(2, 1'b0, PT, CT256, "aes256_enc");
    run_block(2, 1'b1, CT256, PT, "aes256_dec");
  endtask

  task automatic wait_result(input logic [0:127] exp, input string name);
    int lat;
    logic run_ok;
    lat = 1; run_ok = 1'b1;
    while (out_valid[0] !== 1'b1 && lat < 100) begin
      if (in_ready[0] !== 1'b0) run_ok = 1'b0;
      tick();
      lat++;
    end
    $display("[TB] %s out=%h latency=%0d", name, out_data[0], lat);
    tests_run++;
    if (lat != 11 || out_data[0] !== exp || run_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: latency %0d data %h in_ready-low %b, want 11 %h 1", name, lat, out_data[0], exp, run_ok);
    end
  endtask

  task automatic test_back_to_back();
    logic stall_ok;
    in_data = PT; mode = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    tick();
    in_data = CT128; mode = 1'b1;
    wait_result(CT128, "b2b_first");
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_data[0] !== CT128 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) stall_ok = 1'b0;
      tick();
    end
    tests_run++;
    if (stall_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_stall: hold ok %b want 1 (out_data %h in_ready %b)", stall_ok, out_data[0], in_ready[0]);
    end
    out_ready[0] = 1'b1;
    #1;
    tests_run++;
    if (in_ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_release in_ready: got %b want 1", in_ready[0]);
    end
    tick();
    in_data = PT; mode = 1'b0;
    tests_run++;
    if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0 || round_idx[0] !== 4'd1) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: busy %b out_valid %b round_idx %0d want 1 0 1",
               busy[0], out_valid[0], round_idx[0]);
    end
    wait_result(PT, "b2b_second");
    tick();
    in_valid[0] = 1'b0;
    wait_result(CT128, "b2b_third");
    tick();
    tests_run++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_idle: out_valid %b in_ready %b want 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic isolate(input int k, input logic m, input logic [0:127] din,
                         input logic [0:127] exp, input string name);
    int lat;
    logic [0:1919] rw;
    in_data = din; mode = m; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 100) begin
      for (int j = 0; j < 60; j++) rw[32*j +: 32] = $urandom;
      words[k] = rw;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      mode = ~mode;
      tick();
      lat++;
    end
    $display("[TB] %s x=%0d out=%h latency=%0d", name, k, out_data[k], lat);
    tests_run++;
    if (out_data[k] !== exp || lat != 11 + 2 * k) begin
      tests_failed++;
      $display("FAIL %s: data %h latency %0d want %h %0d", name, out_data[k], lat, exp, 11 + 2 * k);
    end
    words[k] = wk[k];
    tick();
  endtask

  task automatic test_isolation();
    isolate(2, 1'b0, PT, CT256, "iso_aes256_enc");
    isolate(0, 1'b1, CT128, PT, "iso_aes128_dec");
  endtask

  task automatic test_reset_mid();
    int n;
    logic stale;
    in_data = PT; mode = 1'b0; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    n = 0;
    while (round_idx[1] !== 4'd5 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (round_idx[1] !== 4'd5) begin
      tests_failed++;
      $display("FAIL mid_reach_round5: round_idx %0d want 5", round_idx[1]);
    end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || busy[1] !== 1'b0 ||
        round_idx[1] !== 4'd0 || out_data[1] !== 128'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: in_ready %b out_valid %b busy %b round_idx %0d out_data %h want 1 0 0 0 0",
               in_ready[1], out_valid[1], busy[1], round_idx[1], out_data[1]);
    end
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid[1] === 1'b1 || busy[1] === 1'b1) stale = 1'b1;
      tick();
    end
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_no_stale: activity after reset %b want 0", stale);
    end
    $display("[TB] reset mid-block done");
    run_block(1, 1'b0, PT, CT192, "post_reset_enc");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      words[k] = '0;
    end
    build_sbox();
    for (int k = 0; k < 3; k++) begin
      wk[k] = expand(k);
      words[k] = wk[k];
    end
    test_reset();
    test_aes128();
    test_aes192_256();
    test_back_to_back();
    test_isolation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
